// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath, with a retired-instruction counter.
// Optional memory handshake stalls are enabled by defining MEM_WAIT_EN.
module multicycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        BranchNe_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        RegDst_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [2:0]  ALU_op_o,
    output logic [1:0]  PCSource_o,
    output logic        illegal_o,
    output logic [31:0] retire_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
    } state_t;

    state_t      state, state_nxt;
    logic        retire;
    logic        mem_done;
    logic [31:0] retire_cnt_q;

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready_i;
`else
    // Memory always completes in one cycle; the handshake input has no effect.
    assign mem_done = mem_ready_i | 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            retire_cnt_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (retire)
                retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt_o = retire_cnt_q;

    always_comb begin
        state_nxt     = state;
        retire        = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchNe_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALU_op_o      = 3'b000;
        PCSource_o    = 2'b00;
        illegal_o     = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALU_op_o  = 3'b010;
                // PC and IR load only on the completing cycle so a stall never double-increments PC.
                if (mem_done) begin
                    PCWrite_o = 1'b1;
                    IRWrite_o = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB_o = 2'b11;
                ALU_op_o  = 3'b010;
                case (instr_op_i)
                    OP_LW, OP_SW:                       state_nxt = MEM_ADDR;
                    OP_RTYPE:                           state_nxt = R_EXEC;
                    OP_BEQ, OP_BNE:                     state_nxt = BRANCH;
                    OP_J:                               state_nxt = JUMP;
                    OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:  state_nxt = I_EXEC;
                    default: begin
                        illegal_o = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = 3'b010;
                state_nxt = (instr_op_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_done)
                    state_nxt = MEM_WB;
            end
            MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                retire     = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_done) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            R_EXEC: begin
                ALUSrcA_o = 1'b1;
                state_nxt = R_WB;
            end
            R_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                retire     = 1'b1;
                state_nxt  = FETCH;
            end
            I_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                case (instr_op_i)
                    OP_SLTIU: ALU_op_o = 3'b111;
                    OP_ORI:   ALU_op_o = 3'b001;
                    OP_LUI:   ALU_op_o = 3'b100;
                    default:  ALU_op_o = 3'b010;
                endcase
                state_nxt = I_WB;
            end
            I_WB: begin
                RegWrite_o = 1'b1;
                retire     = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALU_op_o      = (instr_op_i == OP_BNE) ? 3'b011 : 3'b110;
                BranchNe_o    = (instr_op_i == OP_BNE);
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                retire        = 1'b1;
                state_nxt     = FETCH;
            end
            JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                retire     = 1'b1;
                state_nxt  = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle control vectors, retire counting,
// illegal opcodes, counter wrap, reset mid-instruction and (with MEM_WAIT_EN) memory stalls.
module tb_multicycle_ctrl;

    typedef logic [18:0] vec_t;

    logic        clk, rst_i, mem_ready;
    logic [5:0]  instr_op;
    logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_write, reg_dst, alu_src_a, illegal;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [31:0] retire_cnt;
    vec_t        obs;
    vec_t        seq_buf [5];

    int n_chk  = 0;
    int n_fail = 0;
    int pcw_cnt;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op), .mem_ready_i(mem_ready),
        .PCWrite_o(pc_write), .PCWriteCond_o(pc_write_cond), .BranchNe_o(branch_ne),
        .IorD_o(iord), .MemRead_o(mem_read), .MemWrite_o(mem_write), .IRWrite_o(ir_write),
        .MemtoReg_o(mem_to_reg), .RegWrite_o(reg_write), .RegDst_o(reg_dst),
        .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b), .ALU_op_o(alu_op),
        .PCSource_o(pc_source), .illegal_o(illegal), .retire_cnt_o(retire_cnt)
    );

    assign obs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    always #5 clk = ~clk;

    function automatic vec_t v(input logic pcw, pcwc, bne, io, mr, mw, irw, m2r, rw, rd, sa,
                               input logic [1:0] sb, input logic [2:0] aop,
                               input logic [1:0] ps, input logic ill);
        return {pcw, pcwc, bne, io, mr, mw, irw, m2r, rw, rd, sa, sb, aop, ps, ill};
    endfunction

    //                    pcw pcwc bne io mr mw irw m2r rw rd sa  sb     aop     ps    ill
    vec_t V_F;   assign V_F   = v(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
    vec_t V_D;   assign V_D   = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0);
    vec_t V_DI;  assign V_DI  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1);
    vec_t V_MA;  assign V_MA  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
    vec_t V_MRD; assign V_MRD = v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_MWB; assign V_MWB = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_MWR; assign V_MWR = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_RX;  assign V_RX  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_RWB; assign V_RWB = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_IWB; assign V_IWB = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    vec_t V_J;   assign V_J   = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0);

    function automatic vec_t v_ix(input logic [2:0] aop);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, aop, 2'b00, 0);
    endfunction

    function automatic vec_t v_br(input logic [2:0] aop, input logic bne);
        return v(0, 1, bne, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 2'b01, 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered while the DUT is in FETCH; walks n cycles and expects FETCH again afterwards.
    task automatic run(input string name, input logic [5:0] op, input int n);
        instr_op = op;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_c%0d", name, i), {13'd0, obs}, {13'd0, seq_buf[i]});
            step();
        end
        check($sformatf("%s_next_fetch", name), {13'd0, obs}, {13'd0, V_F});
    endtask

    initial begin
        clk = 1'b0; rst_i = 1'b0; mem_ready = 1'b1; instr_op = 6'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outputs", {13'd0, obs}, 32'd0);
            check("rst_cnt", retire_cnt, 32'd0);
        end
        rst_i = 1'b1;
        #1;
        check("idle_outputs", {13'd0, obs}, 32'd0);
        step();
        check("first_fetch", {13'd0, obs}, {13'd0, V_F});

        seq_buf = '{V_F, V_D, V_RX, V_RWB, 19'd0};        run("rtype", 6'd0, 4);
        seq_buf = '{V_F, V_D, V_MA, V_MRD, V_MWB};        run("lw", 6'd35, 5);
        seq_buf = '{V_F, V_D, V_MA, V_MWR, 19'd0};        run("sw", 6'd43, 4);
        seq_buf = '{V_F, V_D, v_br(3'b110, 1'b0), 19'd0, 19'd0}; run("beq", 6'd4, 3);
        seq_buf = '{V_F, V_D, V_J, 19'd0, 19'd0};          run("j", 6'd2, 3);
        seq_buf = '{V_F, V_D, v_ix(3'b010), V_IWB, 19'd0}; run("addi", 6'd8, 4);
        check("cnt_after_sweep", retire_cnt, 32'd6);

        seq_buf = '{V_F, V_D, v_ix(3'b111), V_IWB, 19'd0}; run("sltiu", 6'd9, 4);
        seq_buf = '{V_F, V_D, v_ix(3'b001), V_IWB, 19'd0}; run("ori", 6'd13, 4);
        seq_buf = '{V_F, V_D, v_ix(3'b100), V_IWB, 19'd0}; run("lui", 6'd15, 4);
        seq_buf = '{V_F, V_D, v_br(3'b011, 1'b1), 19'd0, 19'd0}; run("bne", 6'd5, 3);
        check("cnt_after_alu", retire_cnt, 32'd10);

        seq_buf = '{V_F, V_DI, 19'd0, 19'd0, 19'd0};       run("illegal", 6'h3F, 2);
        check("cnt_after_illegal", retire_cnt, 32'd10);

`ifdef MEM_WAIT_EN
        instr_op = 6'd35;
        pcw_cnt  = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ready = !(c == 0 || c == 1 || c == 5 || c == 6 || c == 7);
            #1;
            pcw_cnt += pc_write;
            if (c == 1) check("stall_fetch_irwrite", {31'd0, ir_write}, 32'd0);
            if (c == 1) check("stall_fetch_memread", {31'd0, mem_read}, 32'd1);
            if (c == 6) check("stall_memrd", {13'd0, obs}, {13'd0, V_MRD});
            if (c == 9) check("stall_wb", {13'd0, obs}, {13'd0, V_MWB});
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        check("stall_next_fetch", {13'd0, obs}, {13'd0, V_F});
        check("stall_pcwrite_once", pcw_cnt, 32'd1);
        check("cnt_after_stall", retire_cnt, 32'd11);
`else
        mem_ready = 1'b0;
        seq_buf = '{V_F, V_D, V_MA, V_MRD, V_MWB};        run("lw_ready_low", 6'd35, 5);
        mem_ready = 1'b1;
        check("cnt_after_ready_low", retire_cnt, 32'd11);
`endif

        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        check("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
        seq_buf = '{V_F, V_D, V_J, 19'd0, 19'd0};          run("wrap_j", 6'd2, 3);
        check("cnt_wrap", retire_cnt, 32'd0);

        instr_op = 6'd35;
        step(); step(); step();
        check("pre_reset_memrd", {13'd0, obs}, {13'd0, V_MRD});
        rst_i = 1'b0;
        #1;
        check("async_reset_outputs", {13'd0, obs}, 32'd0);
        check("async_reset_cnt", retire_cnt, 32'd0);
        step();
        check("reset_no_regwrite_a", {31'd0, reg_write}, 32'd0);
        step();
        check("reset_no_regwrite_b", {31'd0, reg_write}, 32'd0);
        rst_i = 1'b1;
        step();
        check("post_reset_fetch", {13'd0, obs}, {13'd0, V_F});
        check("post_reset_cnt", retire_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
